// File: rtl/cv32e40p_core_v_xif_pkg.sv
// Shared X-interface types for the coprocessor result path.
// x_result_entry_t is one buffered result: {id, rd, data, we}. The id field is
// sized for the widest supported X-interface ID. Narrower instances use the
// low bits and store zeros above them.
package cv32e40p_core_v_xif_pkg;

  localparam int unsigned X_ID_WIDTH_MAX = 8;

  typedef struct packed {
    logic [X_ID_WIDTH_MAX-1:0] id;
    logic [4:0]                rd;
    logic [31:0]               data;
    logic                      we;
  } x_result_entry_t;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Generic in-order FIFO of DEPTH entries, each WIDTH bits wide.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   push, wdata   write one entry; ignored while full
//   pop           drop the head entry; ignored while empty
//   rdata         the head entry. Its value is undefined while the FIFO is empty.
//   full, empty   occupancy flags
// Pointers are one bit narrower than the count, so they wrap naturally modulo DEPTH.
module cv32e40p_x_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + PtrW'(1);
      if (pop_en)  rptr_q <= rptr_q + PtrW'(1);
      if (push_en && !pop_en)      count_q <= count_q + (PtrW+1)'(1);
      else if (!push_en && pop_en) count_q <= count_q - (PtrW+1)'(1);
    end
  end

  // Storage needs no reset: a slot is always written before the read pointer reaches it.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cv32e40p_x_result_tx.sv
// Buffers coprocessor results and forwards them to the core over the X-interface.
// A result is forwarded only after the core has committed its ID.
// Ports:
//   clk, rst_n                        clock and asynchronous active-low reset
//   res_valid_i/res_ready_o/res_*_i   results arriving from the execution unit
//   x_commit_valid_i/_id_i/_kill_i    commit transactions from the core
//   x_result_valid_o/_ready_i/_*_o    results offered to the core (fields zero when idle)
//   empty_o                           the buffer holds no entries
// The per-ID commit table lives here. A head entry that is committed but killed
// is dropped silently.
module cv32e40p_x_result_tx
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4   // must not exceed X_ID_WIDTH_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  logic [X_ID_WIDTH-1:0] res_id_i,
  input  logic [4:0]            res_rd_i,
  input  logic [31:0]           res_data_i,
  input  logic                  res_we_i,
  input  logic                  x_commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] x_commit_id_i,
  input  logic                  x_commit_kill_i,
  output logic                  x_result_valid_o,
  input  logic                  x_result_ready_i,
  output logic [X_ID_WIDTH-1:0] x_result_id_o,
  output logic [4:0]            x_result_rd_o,
  output logic [31:0]           x_result_data_o,
  output logic                  x_result_we_o,
  output logic                  empty_o
);

  localparam int unsigned NumIds = 2 ** X_ID_WIDTH;
  localparam int unsigned EntryW = $bits(x_result_entry_t);

  x_result_entry_t       push_entry, head_entry;
  logic [EntryW-1:0]     head_raw;
  logic                  full, empty, push, pop, send, drop;
  logic [X_ID_WIDTH-1:0] head_id;
  logic [NumIds-1:0]     committed_q, committed_d, killed_q, killed_d;

  always_comb begin
    push_entry                     = '0;
    push_entry.id[X_ID_WIDTH-1:0]  = res_id_i;
    push_entry.rd                  = res_rd_i;
    push_entry.data                = res_data_i;
    push_entry.we                  = res_we_i;
  end

  assign res_ready_o = ~full;
  assign push        = res_valid_i & res_ready_o;

  cv32e40p_x_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_raw),
    .full  (full),
    .empty (empty)
  );

  assign head_entry = x_result_entry_t'(head_raw);
  assign head_id    = head_entry.id[X_ID_WIDTH-1:0];

  if (X_ID_WIDTH < X_ID_WIDTH_MAX) begin : gen_id_hi_unused
    logic unused_id_hi;
    assign unused_id_hi = ^head_entry.id[X_ID_WIDTH_MAX-1:X_ID_WIDTH];
  end

  // Valid and drop depend only on registered state, never on x_result_ready_i.
  assign send = ~empty & committed_q[head_id] & ~killed_q[head_id];
  assign drop = ~empty & committed_q[head_id] & killed_q[head_id];
  assign pop  = (send & x_result_ready_i) | drop;

  // Clear the popped ID first, so that a same-cycle commit of that ID sets it again.
  always_comb begin
    committed_d = committed_q;
    killed_d    = killed_q;
    if (pop) begin
      committed_d[head_id] = 1'b0;
      killed_d[head_id]    = 1'b0;
    end
    if (x_commit_valid_i) begin
      committed_d[x_commit_id_i] = 1'b1;
      killed_d[x_commit_id_i]    = x_commit_kill_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      committed_q <= '0;
      killed_q    <= '0;
    end else begin
      committed_q <= committed_d;
      killed_q    <= killed_d;
    end
  end

  // The fields are gated by valid, so they read as zero while nothing is offered.
  assign x_result_valid_o = send;
  assign x_result_id_o    = send ? head_id         : '0;
  assign x_result_rd_o    = send ? head_entry.rd   : '0;
  assign x_result_data_o  = send ? head_entry.data : '0;
  assign x_result_we_o    = send & head_entry.we;
  assign empty_o          = empty;

endmodule

// File: tb/tb_cv32e40p_x_result_tx.sv
// Directed and randomized bench for cv32e40p_x_result_tx against a queue-based reference model.
module tb_cv32e40p_x_result_tx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [XW-1:0] res_id = '0;
  logic [4:0]    res_rd = '0;
  logic [31:0]   res_data = '0;
  logic          res_we = 1'b0;
  logic          c_valid = 1'b0;
  logic [XW-1:0] c_id = '0;
  logic          c_kill = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [XW-1:0] o_id;
  logic [4:0]    o_rd;
  logic [31:0]   o_data;
  logic          o_we;
  logic          empty;

  always #5 clk = ~clk;

  cv32e40p_x_result_tx #(
    .DEPTH      (DEPTH),
    .X_ID_WIDTH (XW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .res_valid_i      (res_valid),
    .res_ready_o      (res_ready),
    .res_id_i         (res_id),
    .res_rd_i         (res_rd),
    .res_data_i       (res_data),
    .res_we_i         (res_we),
    .x_commit_valid_i (c_valid),
    .x_commit_id_i    (c_id),
    .x_commit_kill_i  (c_kill),
    .x_result_valid_o (o_valid),
    .x_result_ready_i (o_ready),
    .x_result_id_o    (o_id),
    .x_result_rd_o    (o_rd),
    .x_result_data_o  (o_data),
    .x_result_we_o    (o_we),
    .empty_o          (empty)
  );

  typedef struct {
    logic [XW-1:0] id;
    logic [4:0]    rd;
    logic [31:0]   data;
    logic          we;
  } ent_t;

  // Reference model: pending results in arrival order plus commit/kill flags per ID.
  ent_t mq[$];
  bit   m_com[2**XW];
  bit   m_kil[2**XW];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    res_valid = 1'b0;
    c_valid   = 1'b0;
    c_kill    = 1'b0;
  endtask

  task automatic offer(input logic [XW-1:0] id, input logic [4:0] rd, input logic [31:0] d,
                       input logic we);
    res_valid = 1'b1;
    res_id    = id;
    res_rd    = rd;
    res_data  = d;
    res_we    = we;
  endtask

  task automatic commit(input logic [XW-1:0] id, input logic kill);
    c_valid = 1'b1;
    c_id    = id;
    c_kill  = kill;
  endtask

  // Check the outputs against the model, then advance one clock with the current inputs.
  task automatic cycle();
    bit   ev, dr, do_push;
    ent_t h;
    h  = '{id: '0, rd: '0, data: '0, we: 1'b0};
    ev = 1'b0;
    dr = 1'b0;
    if (mq.size() > 0) begin
      h  = mq[0];
      ev = m_com[h.id] && !m_kil[h.id];
      dr = m_com[h.id] && m_kil[h.id];
    end
    chk("valid", o_valid, ev);
    chk("res_ready", res_ready, mq.size() < DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("id", o_id, ev ? h.id : '0);
    chk("rd", o_rd, ev ? h.rd : '0);
    chk("data", o_data, ev ? h.data : '0);
    chk("we", o_we, ev ? h.we : 1'b0);
    do_push = res_valid && (mq.size() < DEPTH);
    if ((ev && o_ready) || dr) begin
      m_com[h.id] = 1'b0;
      m_kil[h.id] = 1'b0;
      void'(mq.pop_front());
    end
    if (c_valid) begin
      m_com[c_id] = 1'b1;
      m_kil[c_id] = c_kill;
    end
    if (do_push) mq.push_back('{id: res_id, rd: res_rd, data: res_data, we: res_we});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, o_valid, 1'b0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_ready"}, res_ready, 1'b1);
    chk({tag, "_fields"}, {o_id, o_rd, o_data, o_we}, '0);
  endtask

  // Assert reset mid-cycle, check the outputs while it is held, then release it away from an edge.
  task automatic apply_reset(input string tag);
    idle();
    o_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks(tag);
    mq.delete();
    for (int i = 0; i < 2**XW; i++) begin
      m_com[i] = 1'b0;
      m_kil[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    #1;
    reset_checks("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Push and commit in the same cycle; the result is valid next cycle and held while stalled.
    offer(4'd3, 5'd5, 32'hDEADBEEF, 1'b1);
    commit(4'd3, 1'b0);
    cycle();
    idle();
    chk("r034_valid", o_valid, 1'b1);
    chk("r034_fields", {o_id, o_rd, o_data, o_we}, {4'd3, 5'd5, 32'hDEADBEEF, 1'b1});
    repeat (3) cycle();
    o_ready = 1'b1;
    cycle();
    o_ready = 1'b0;
    chk("r034_empty", empty, 1'b1);
    cycle();

    // Results leave in push order, whatever the commit order.
    offer(4'd1, 5'd1, 32'h1111_0001, 1'b1);
    cycle();
    offer(4'd2, 5'd2, 32'h2222_0002, 1'b0);
    cycle();
    idle();
    commit(4'd2, 1'b0);
    cycle();
    idle();
    chk("r035_wait", o_valid, 1'b0);
    commit(4'd1, 1'b0);
    cycle();
    idle();
    chk("r035_first", o_id, 4'd1);
    o_ready = 1'b1;
    cycle();
    chk("r035_second", o_id, 4'd2);
    cycle();
    o_ready = 1'b0;
    cycle();

    // A killed result is dropped without ever being offered, and its table entry is cleared.
    offer(4'd7, 5'd7, 32'h7777_7777, 1'b1);
    cycle();
    idle();
    commit(4'd7, 1'b1);
    cycle();
    idle();
    chk("r036_novalid", o_valid, 1'b0);
    cycle();
    chk("r036_empty", empty, 1'b1);
    offer(4'd7, 5'd8, 32'h0707_0707, 1'b1);
    cycle();
    idle();
    repeat (3) cycle();
    chk("r036_cleared", o_valid, 1'b0);
    commit(4'd7, 1'b0);
    o_ready = 1'b1;
    cycle();
    idle();
    cycle();
    o_ready = 1'b0;
    cycle();

    // A full buffer keeps refusing pushes during the popping cycle and accepts on the next one.
    offer(4'd4, 5'd4, 32'h4, 1'b1); cycle();
    offer(4'd5, 5'd0, 32'h5, 1'b1); cycle();
    offer(4'd6, 5'd6, 32'h6, 1'b0); cycle();
    offer(4'd8, 5'd8, 32'h8, 1'b1); cycle();
    chk("r037_full", res_ready, 1'b0);
    offer(4'd10, 5'd10, 32'hA, 1'b1);
    commit(4'd4, 1'b0);
    cycle();
    c_valid = 1'b0;
    o_ready = 1'b1;
    chk("r037_popcycle_ready", res_ready, 1'b0);
    cycle();
    chk("r037_next_ready", res_ready, 1'b1);
    cycle();
    res_valid = 1'b0;
    commit(4'd5, 1'b0); cycle();
    commit(4'd6, 1'b0); cycle();
    commit(4'd8, 1'b0); cycle();
    commit(4'd10, 1'b0); cycle();
    idle();
    repeat (3) cycle();
    chk("r037_drained", empty, 1'b1);
    o_ready = 1'b0;

    // A commit that arrives early still gives one-cycle latency once the result is pushed.
    commit(4'd9, 1'b0);
    cycle();
    idle();
    repeat (4) cycle();
    offer(4'd9, 5'd9, 32'h9999_0000, 1'b1);
    cycle();
    idle();
    chk("r038_valid", o_valid, 1'b1);
    o_ready = 1'b1;
    cycle();
    o_ready = 1'b0;
    cycle();

    // Reset while a result is pending clears it; a stale commit must not survive the reset.
    offer(4'd12, 5'd12, 32'hC0C0_C0C0, 1'b1);
    commit(4'd12, 1'b0);
    cycle();
    idle();
    commit(4'd5, 1'b0);
    chk("r039_pending", o_valid, 1'b1);
    cycle();
    apply_reset("r039");
    cycle();
    offer(4'd5, 5'd3, 32'h5555_5555, 1'b1);
    cycle();
    offer(4'd12, 5'd4, 32'h1212_1212, 1'b1);
    cycle();
    idle();
    repeat (3) cycle();
    chk("r039_stale", o_valid, 1'b0);
    apply_reset("mid");
    cycle();

    // Randomized traffic, with commits aimed mostly at IDs that are still pending.
    for (int n = 0; n < 400; n++) begin
      res_valid = 1'($urandom_range(1, 0));
      res_id    = XW'($urandom_range(2**XW - 1, 0));
      res_rd    = 5'($urandom);
      res_data  = $urandom;
      res_we    = 1'($urandom);
      c_valid   = ($urandom_range(2, 0) == 0);
      if (mq.size() > 0 && $urandom_range(3, 0) != 0) begin
        idx  = $urandom_range(mq.size() - 1, 0);
        c_id = mq[idx].id;
      end else begin
        c_id = XW'($urandom_range(2**XW - 1, 0));
      end
      c_kill  = ($urandom_range(3, 0) == 0);
      o_ready = 1'($urandom_range(1, 0));
      cycle();
    end
    idle();
    o_ready = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_result_tx.md
CV32E40P_X_RESULT_TX -- requirements
Module: cv32e40p_x_result_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter X_ID_WIDTH, default 4, X-interface instruction-ID width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port res_valid_i, input, 1 bit: the coprocessor execution unit offers a completed result.
REQ-006 SHALL have port res_ready_o, output, 1 bit: the buffer accepts the offered result.
REQ-007 SHALL have port res_id_i, input, X_ID_WIDTH bits: ID of the offered result.
REQ-008 SHALL have port res_rd_i, input, 5 bits: destination register of the offered result.
REQ-009 SHALL have port res_data_i, input, 32 bits: data of the offered result.
REQ-010 SHALL have port res_we_i, input, 1 bit: write-enable of the offered result.
REQ-011 SHALL have port x_commit_valid_i, input, 1 bit: commit transaction from the core.
REQ-012 SHALL have port x_commit_id_i, input, X_ID_WIDTH bits: ID being committed.
REQ-013 SHALL have port x_commit_kill_i, input, 1 bit: the committed ID is killed.
REQ-014 SHALL have port x_result_valid_o, output, 1 bit: result offered to the core.
REQ-015 SHALL have port x_result_ready_i, input, 1 bit: the core accepts the result.
REQ-016 SHALL have ports x_result_id_o (X_ID_WIDTH bits), x_result_rd_o (5 bits), x_result_data_o (32 bits) and x_result_we_o (1 bit), all outputs: fields of the offered result.
REQ-017 SHALL have port empty_o, output, 1 bit: buffer holds no entries.

Function
REQ-018 SHALL store results in an in-order FIFO of DEPTH entries {id, rd, data, we}, with a push on res_valid_i & res_ready_o.
REQ-019 SHALL drive res_ready_o = (count < DEPTH), independent of same-cycle pop; there is no full-buffer bypass.
REQ-020 SHALL keep a per-ID commit table of 2^X_ID_WIDTH entries {committed, killed}; x_commit_valid_i sets committed[id]=1 and killed[id]=x_commit_kill_i, registered.
REQ-021 SHALL assert x_result_valid_o iff the FIFO is non-empty, committed[head.id]=1 and killed[head.id]=0; the fields SHALL equal the head entry.
REQ-022 SHALL pop the head on x_result_valid_o & x_result_ready_i.
REQ-023 SHALL pop the head silently within one cycle, with no valid asserted, when committed[head.id]=1 and killed[head.id]=1.
REQ-024 SHALL clear committed and killed for the popped ID on every pop, whether sent or dropped; a same-cycle commit of the same ID SHALL win (set over clear).
REQ-025 SHALL hold x_result_valid_o and all fields stable until accepted; there SHALL be no combinational path from x_result_ready_i to x_result_valid_o.
REQ-026 SHALL make latency exactly one cycle when the result is pushed and committed in cycle N into an empty FIFO: x_result_valid_o rises in cycle N+1.
REQ-027 SHALL leave count unchanged on simultaneous push and pop; pointers SHALL wrap modulo DEPTH.
REQ-028 SHALL transmit entries with we=0 or rd=0 unchanged; filtering of those entries is done by the core.
REQ-029 SHALL allow a commit to arrive before, with, or after the result push; the ordering of commit and result SHALL NOT change behaviour.

Reset
REQ-030 SHALL, on rst_n low, clear count, pointers and the commit table, drive res_ready_o=1 (after reset), x_result_valid_o=0 and empty_o=1, and zero all x_result_* fields.
REQ-031 SHALL discard all buffered and uncommitted state when reset is asserted mid-transfer, with no output glitch to valid after release.

Structure
REQ-032 SHALL place the result-entry struct type (id, rd, data, we) in the shared package cv32e40p_core_v_xif_pkg.
REQ-033 SHALL use one sub-module, cv32e40p_x_result_fifo (generic DEPTH FIFO), with the commit table kept in the top level.

Verification
REQ-034 Push id=3, rd=5, data=0xDEADBEEF, we=1 together with commit id=3 kill=0 -> valid in the next cycle with those exact fields; hold ready=0 for 3 cycles -> fields stable; ready=1 -> pop, empty_o=1.
REQ-035 Push ids 1,2; commit 2 then 1 -> id 1 is sent first, then id 2 (in order).
REQ-036 Push id=7; commit id=7 kill=1 -> no valid ever, entry dropped in 1 cycle, empty_o=1, commit-table entry 7 cleared.
REQ-037 Fill 4 entries with no commits -> res_ready_o=0; commit the head and pop while res_valid_i=1 -> no push that cycle, push on the next.
REQ-038 Commit id=9 five cycles before pushing id=9 -> valid one cycle after the push.
REQ-039 Assert rst_n=0 while valid is pending with ready=0 -> valid=0 and empty_o=1 immediately; a stale commit does not resurrect after release.
